// File: rtl/sched_pkg.sv
// Shared types and constants for the barrel-pipeline issue scheduler.
package sched_pkg;

  typedef enum logic {T_IDLE, T_RUN} thread_state_t;

  localparam int NTHREAD = 4;
  localparam int PC_W    = 9;
  localparam int TID_W   = $clog2(NTHREAD);
  localparam int PC_INC  = 4;

endpackage

// File: rtl/thread_scheduler_rr_picker.sv
// Combinational rotating-priority encoder: searches req starting at last_tid+1.
module rr_picker
  import sched_pkg::*;
#(
  parameter int N  = NTHREAD,
  parameter int TW = TID_W
) (
  input  logic [N-1:0]  req,
  input  logic [TW-1:0] last_tid,
  output logic          gnt_valid,
  output logic [TW-1:0] gnt_tid
);

  logic [TW-1:0] idx;

  // Scan from farthest to nearest so the closest requester after last_tid wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_tid   = last_tid;
    idx       = last_tid;
    for (int k = N; k >= 1; k--) begin
      idx = last_tid + TW'(k);
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_tid   = idx;
      end
    end
  end

endmodule

// File: rtl/thread_scheduler.sv
// Per-thread PC/run-state holder and round-robin issue picker feeding IMEM.
module thread_scheduler #(
  parameter int NTHREAD = 4,
  parameter int PC_W    = 9,
  parameter int MIN_GAP = 4
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               start,
  input  logic [1:0]         start_tid,
  input  logic [PC_W-1:0]    start_pc,
  input  logic               halt,
  input  logic [1:0]         halt_tid,
  input  logic               ex_branch,
  input  logic [1:0]         ex_tid,
  input  logic [PC_W-1:0]    ex_target,
  output logic               issue_valid,
  output logic [1:0]         issue_tid,
  output logic [PC_W-1:0]    issue_pc,
  output logic [NTHREAD-1:0] thread_active,
  output logic               busy
);

  import sched_pkg::*;

  localparam int GAP_W = 4;

  thread_state_t     state [NTHREAD];
  logic [PC_W-1:0]   pc    [NTHREAD];
  logic [GAP_W-1:0]  gap   [NTHREAD];
  logic [TID_W-1:0]  last_tid;

  logic [NTHREAD-1:0] elig_p0;
  logic               gnt_valid_p0;
  logic [TID_W-1:0]   gnt_tid_p0;
  logic [PC_W-1:0]    eff_pc_p0;

  logic               vld_p1;
  logic [TID_W-1:0]   tid_p1;
  logic [PC_W-1:0]    pc_p1;

  function automatic logic [PC_W-1:0] pc_advance(input logic [PC_W-1:0] p);
    return p + PC_W'(PC_INC);
  endfunction

  // Stage p0: eligibility, pick, and branch-bypassed fetch address.
  always_comb begin
    for (int i = 0; i < NTHREAD; i++) begin
      elig_p0[i] = (state[i] == T_RUN) && (gap[i] == '0) &&
                   !(halt && (halt_tid == TID_W'(i)));
    end
  end

  rr_picker #(
    .N  (NTHREAD),
    .TW (TID_W)
  ) u_picker (
    .req       (elig_p0),
    .last_tid  (last_tid),
    .gnt_valid (gnt_valid_p0),
    .gnt_tid   (gnt_tid_p0)
  );

  assign eff_pc_p0 = (ex_branch && (ex_tid == gnt_tid_p0)) ? ex_target : pc[gnt_tid_p0];

  // Stage p1: thread state update and registered issue slot.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      last_tid <= TID_W'(NTHREAD - 1);
      vld_p1   <= 1'b0;
      tid_p1   <= '0;
      pc_p1    <= '0;
      for (int i = 0; i < NTHREAD; i++) begin
        state[i] <= T_IDLE;
        pc[i]    <= '0;
        gap[i]   <= '0;
      end
    end else begin
      vld_p1 <= gnt_valid_p0;
      if (gnt_valid_p0) begin
        tid_p1   <= gnt_tid_p0;
        pc_p1    <= eff_pc_p0;
        last_tid <= gnt_tid_p0;
      end
      for (int i = 0; i < NTHREAD; i++) begin
        if (halt && (halt_tid == TID_W'(i))) begin
          state[i] <= T_IDLE;
          if (gap[i] != '0) gap[i] <= gap[i] - 1'b1;
        end else if (start && (start_tid == TID_W'(i))) begin
          // A restart wins over a same-cycle issue or branch for this thread.
          state[i] <= T_RUN;
          pc[i]    <= start_pc;
          gap[i]   <= '0;
        end else if (gnt_valid_p0 && (gnt_tid_p0 == TID_W'(i))) begin
          pc[i]  <= pc_advance(eff_pc_p0);
          gap[i] <= GAP_W'(MIN_GAP - 1);
        end else begin
          if (ex_branch && (ex_tid == TID_W'(i)) && (state[i] == T_RUN)) pc[i] <= ex_target;
          if (gap[i] != '0) gap[i] <= gap[i] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NTHREAD; i++) thread_active[i] = (state[i] == T_RUN);
  end

  assign busy        = |thread_active;
  assign issue_valid = vld_p1;
  assign issue_tid   = tid_p1;
  assign issue_pc    = pc_p1;

endmodule
